// File: rtl/sram_bank_xbar_pkg.sv
// Shared types and index-width helpers for the banked SRAM crossbar.
package sram_xbar_pkg;

    localparam int MACRO_AW = 9;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic        err;
        logic [31:0] rdata;
    } obi_rsp_t;

    typedef struct packed {
        logic                cs;
        logic                we;
        logic [3:0]          be;
        logic [MACRO_AW-1:0] word;
        logic [31:0]         wdata;
    } bank_cmd_t;

    function automatic int unsigned log2_ceil(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned bank_idx_bits(input int unsigned num_banks);
        return log2_ceil(num_banks);
    endfunction

    function automatic int unsigned word_idx_bits(input int unsigned bank_words);
        return log2_ceil(bank_words);
    endfunction

endpackage

// File: rtl/sky130_sram_2kbyte_1rw1r_32x512_8.sv
// Behavioural model of the 2 KiB 1rw1r SRAM macro: active-low selects, byte write mask, registered reads.
module sky130_sram_2kbyte_1rw1r_32x512_8 (
    input  logic        clk0,
    input  logic        csb0,
    input  logic        web0,
    input  logic [3:0]  wmask0,
    input  logic [8:0]  addr0,
    input  logic [31:0] din0,
    output logic [31:0] dout0,
    input  logic        clk1,
    input  logic        csb1,
    input  logic [8:0]  addr1,
    output logic [31:0] dout1
);

    logic [31:0] mem [512];

    always_ff @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++) begin
                    if (wmask0[b]) mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
                end
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (!csb1) dout1 <= mem[addr1];
    end

endmodule

// File: rtl/sram_bank_xbar_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer moves to winner+1 only when something is granted.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_reg, ptr_next;
    logic [N-1:0]  masked, pick;
    logic          found;

    // Requests at or above the pointer take priority; otherwise wrap to the lowest requester.
    always_comb begin
        masked = '0;
        for (int j = 0; j < N; j++) masked[j] = req[j] && (j >= int'(ptr_reg));
        pick     = (|masked) ? masked : req;
        gnt      = '0;
        found    = 1'b0;
        ptr_next = ptr_reg;
        for (int j = 0; j < N; j++) begin
            if (pick[j] && !found) begin
                gnt[j]   = 1'b1;
                found    = 1'b1;
                ptr_next = (j == N - 1) ? '0 : PW'(j + 1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ptr_reg <= '0;
        else       ptr_reg <= ptr_next;
    end

endmodule

// File: rtl/sram_bank_xbar.sv
// OBI multi-port crossbar onto NUM_BANKS SRAM macros, one round-robin arbiter per bank.
// Optional SRAM_RANGE_CHECK_EN: out-of-range requests get an immediate grant and an error response.
module sram_bank_xbar
    import sram_xbar_pkg::*;
#(
    parameter int          NUM_PORTS  = 2,
    parameter int          NUM_BANKS  = 8,
    parameter int          BANK_WORDS = 512,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_PORTS-1:0]    req_i,
    output logic [NUM_PORTS-1:0]    gnt_o,
    input  logic [NUM_PORTS*32-1:0] addr_i,
    input  logic [NUM_PORTS-1:0]    we_i,
    input  logic [NUM_PORTS*4-1:0]  be_i,
    input  logic [NUM_PORTS*32-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]    rvalid_o,
    output logic [NUM_PORTS*32-1:0] rdata_o,
    output logic [NUM_PORTS-1:0]    err_o,
    output logic                    illegal_memory_o
);

    localparam int BW = int'(bank_idx_bits(NUM_BANKS));
    localparam int WW = int'(word_idx_bits(BANK_WORDS));
    localparam int AW = 2 + WW + BW;

    obi_req_t             port_req [NUM_PORTS];
    obi_rsp_t             port_rsp [NUM_PORTS];
    logic [BW-1:0]        bank_idx [NUM_PORTS];
    logic [WW-1:0]        word_idx [NUM_PORTS];
    logic [NUM_PORTS-1:0] in_range;
    logic [NUM_PORTS-1:0] oor_req;
    logic [NUM_PORTS-1:0] port_gnt;
    logic [NUM_PORTS-1:0] bank_gnt [NUM_BANKS];
    logic [31:0]          bank_dout [NUM_BANKS];

    genvar gi;

    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        logic          rvalid_reg;
        logic          rd_reg;
        logic [BW-1:0] bank_sel_reg;
        logic          err_bit;

        // Requests are masked during reset so no bank sees a chip select.
        assign port_req[gi] = '{
            req:   req_i[gi] & ~rst_i,
            we:    we_i[gi],
            be:    be_i[gi*4 +: 4],
            addr:  addr_i[gi*32 +: 32],
            wdata: wdata_i[gi*32 +: 32]
        };
        assign bank_idx[gi] = port_req[gi].addr[2+WW +: BW];
        assign word_idx[gi] = port_req[gi].addr[2 +: WW];
        assign oor_req[gi]  = port_req[gi].req & ~in_range[gi];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rvalid_reg   <= 1'b0;
                rd_reg       <= 1'b0;
                bank_sel_reg <= '0;
            end else begin
                rvalid_reg <= port_gnt[gi];
                rd_reg     <= port_gnt[gi] & in_range[gi] & ~port_req[gi].we;
                if (port_gnt[gi]) bank_sel_reg <= bank_idx[gi];
            end
        end

`ifdef SRAM_RANGE_CHECK_EN
        logic err_reg;
        logic unused_addr_bits;

        assign in_range[gi]     = (port_req[gi].addr[31:AW] == BASE_ADDR[31:AW]);
        assign unused_addr_bits = ^port_req[gi].addr[1:0];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) err_reg <= 1'b0;
            else       err_reg <= oor_req[gi];
        end
        assign err_bit = err_reg;
`else
        logic unused_addr_bits;

        // Upper address bits are ignored, so the memory aliases across the whole map.
        assign in_range[gi]     = 1'b1;
        assign unused_addr_bits = ^{port_req[gi].addr[31:AW], port_req[gi].addr[1:0]};
        assign err_bit          = 1'b0;
`endif

        assign port_rsp[gi] = '{
            gnt:    port_gnt[gi],
            rvalid: rvalid_reg,
            err:    err_bit,
            rdata:  (rvalid_reg && rd_reg) ? bank_dout[bank_sel_reg] : 32'h0
        };
        assign gnt_o[gi]            = port_rsp[gi].gnt;
        assign rvalid_o[gi]         = port_rsp[gi].rvalid;
        assign err_o[gi]            = port_rsp[gi].err;
        assign rdata_o[gi*32 +: 32] = port_rsp[gi].rdata;
    end

    always_comb begin
        port_gnt = oor_req;
        for (int b = 0; b < NUM_BANKS; b++) port_gnt = port_gnt | bank_gnt[b];
    end

`ifdef SRAM_RANGE_CHECK_EN
    assign illegal_memory_o = |oor_req;
`else
    assign illegal_memory_o = 1'b0;
`endif

    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic [NUM_PORTS-1:0] hit;
        logic [NUM_PORTS-1:0] gnt;
        bank_cmd_t            cmd;
        logic [31:0]          dout1_unused;

        always_comb begin
            hit = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                hit[p] = port_req[p].req & in_range[p] & (bank_idx[p] == BW'(gi));
            end
        end

        rr_arbiter #(.N(NUM_PORTS)) u_arb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .req   (hit),
            .gnt   (gnt)
        );
        assign bank_gnt[gi] = gnt;

        // gnt is one-hot, so at most one port's fields reach the macro.
        always_comb begin
            cmd = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (gnt[p]) begin
                    cmd.cs    = 1'b1;
                    cmd.we    = port_req[p].we;
                    cmd.be    = port_req[p].be;
                    cmd.word  = MACRO_AW'(word_idx[p]);
                    cmd.wdata = port_req[p].wdata;
                end
            end
        end

        sky130_sram_2kbyte_1rw1r_32x512_8 u_sram (
            .clk0   (clk_i),
            .csb0   (~cmd.cs),
            .web0   (~cmd.we),
            .wmask0 (cmd.be),
            .addr0  (cmd.word),
            .din0   (cmd.wdata),
            .dout0  (bank_dout[gi]),
            .clk1   (clk_i),
            .csb1   (1'b1),
            .addr1  ({MACRO_AW{1'b0}}),
            .dout1  (dout1_unused)
        );
    end

endmodule

// File: tb/tb_sram_bank_xbar.sv
// Directed bench for sram_bank_xbar: grants checked per cycle, responses against a queued memory model.
module tb_sram_bank_xbar;

    localparam int NP = 2;

`ifdef SRAM_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [NP-1:0]    req_i, we_i, gnt_o, rvalid_o, err_o;
    logic [NP*32-1:0] addr_i, wdata_i, rdata_o;
    logic [NP*4-1:0]  be_i;
    logic             illegal_memory_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mem_model [int];

    always #5 clk_i = ~clk_i;

    sram_bank_xbar #(
        .NUM_PORTS  (NP),
        .NUM_BANKS  (8),
        .BANK_WORDS (512),
        .BASE_ADDR  (32'h8000_0000)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_i            (req_i),
        .gnt_o            (gnt_o),
        .addr_i           (addr_i),
        .we_i             (we_i),
        .be_i             (be_i),
        .wdata_i          (wdata_i),
        .rvalid_o         (rvalid_o),
        .rdata_o          (rdata_o),
        .err_o            (err_o),
        .illegal_memory_o (illegal_memory_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic rq, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        req_i[p]            = rq;
        we_i[p]             = w;
        addr_i[p*32 +: 32]  = a;
        be_i[p*4 +: 4]      = b;
        wdata_i[p*32 +: 32] = d;
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    function automatic logic in_map(input logic [31:0] a);
        return !RANGE_CHK || (a[31:14] == 18'h20000);
    endfunction

    // At the falling edge: retire last cycle's responses, check this cycle's grants, queue new ones.
    task automatic sample(input logic [1:0] exp_gnt, input logic exp_ill, input string tag);
        exp_t        e;
        logic        has;
        logic [31:0] a, cur;
        int          k;
        @(negedge clk_i);
        for (int p = 0; p < NP; p++) begin
            has = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
            chk($sformatf("%s rvalid%0d", tag, p), 32'(rvalid_o[p]), 32'(has));
            if (has) begin
                if (p == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                $display("txn %s port%0d rdata=%h err=%0b", tag, p, rdata_o[p*32 +: 32], err_o[p]);
                chk($sformatf("%s rdata%0d", tag, p), rdata_o[p*32 +: 32], e.rdata);
                chk($sformatf("%s err%0d", tag, p), 32'(err_o[p]), 32'(e.err));
            end else begin
                chk($sformatf("%s idle_rdata%0d", tag, p), rdata_o[p*32 +: 32], 32'h0);
                chk($sformatf("%s idle_err%0d", tag, p), 32'(err_o[p]), 32'h0);
            end
        end
        chk($sformatf("%s gnt", tag), 32'(gnt_o), 32'(exp_gnt));
        chk($sformatf("%s illegal", tag), 32'(illegal_memory_o), 32'(exp_ill));
        for (int p = 0; p < NP; p++) begin
            if (exp_gnt[p]) begin
                a = addr_i[p*32 +: 32];
                k = int'(a[13:2]);
                if (!in_map(a)) begin
                    e = '{rdata: 32'h0, err: 1'b1};
                end else if (we_i[p]) begin
                    cur = mem_model.exists(k) ? mem_model[k] : 32'h0;
                    for (int b = 0; b < 4; b++) begin
                        if (be_i[p*4 + b]) cur[b*8 +: 8] = wdata_i[p*32 + b*8 +: 8];
                    end
                    mem_model[k] = cur;
                    e = '{rdata: 32'h0, err: 1'b0};
                end else begin
                    e = '{rdata: mem_model[k], err: 1'b0};
                end
                if (p == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endtask

    task automatic advance();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cycle(input logic [1:0] exp_gnt, input logic exp_ill, input string tag);
        sample(exp_gnt, exp_ill, tag);
        advance();
    endtask

    initial begin
        rst_i = 1'b0;
        idle_all();
        #1 rst_i = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h8000_1800, 4'hF, 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        cycle(2'b00, 1'b0, "reset_state");
        rst_i = 1'b0;
        idle_all();

        // Single-port write then readback
        drive(0, 1'b1, 1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF);
        cycle(2'b01, 1'b0, "wr_deadbeef");
        drive(0, 1'b1, 1'b0, 32'h8000_0010, 4'hF, 32'h0);
        cycle(2'b01, 1'b0, "rd_deadbeef");
        idle_all();
        cycle(2'b00, 1'b0, "rd_deadbeef_resp");

        // Same-bank conflict on bank 3: P0 first, P1 next cycle
        drive(0, 1'b1, 1'b1, 32'h8000_1800, 4'hF, 32'h3333_0000);
        drive(1, 1'b1, 1'b1, 32'h8000_1804, 4'hF, 32'h3333_0001);
        cycle(2'b01, 1'b0, "b3_conflict");
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cycle(2'b10, 1'b0, "b3_loser");

        // Different banks granted together
        drive(0, 1'b1, 1'b1, 32'h8000_0000, 4'hF, 32'hB0B0_0000);
        drive(1, 1'b1, 1'b1, 32'h8000_2800, 4'hF, 32'h5555_5555);
        cycle(2'b11, 1'b0, "wr_b0_b5");
        drive(0, 1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h8000_2800, 4'hF, 32'h0);
        cycle(2'b11, 1'b0, "rd_b0_b5");

        // Both ports read bank 3 continuously: strict alternation
        drive(0, 1'b1, 1'b0, 32'h8000_1800, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h8000_1804, 4'hF, 32'h0);
        for (int i = 0; i < 6; i++) begin
            cycle((i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, $sformatf("rr_b3_%0d", i));
        end

        // Byte-enable merge
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(0, 1'b1, 1'b1, 32'h8000_0020, 4'hF, 32'h1122_3344);
        cycle(2'b01, 1'b0, "be_full");
        drive(0, 1'b1, 1'b1, 32'h8000_0020, 4'b0010, 32'h0000_AB00);
        cycle(2'b01, 1'b0, "be_byte1");
        drive(0, 1'b1, 1'b0, 32'h8000_0020, 4'hF, 32'h0);
        cycle(2'b01, 1'b0, "be_readback");

        // Same-word read/write in one cycle: bank 0 pointer favours P1, so the read sees old data
        drive(0, 1'b1, 1'b1, 32'h8000_0020, 4'hF, 32'hCAFE_F00D);
        drive(1, 1'b1, 1'b0, 32'h8000_0020, 4'hF, 32'h0);
        cycle(2'b10, 1'b0, "rw_same_rd_old");
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cycle(2'b01, 1'b0, "rw_same_wr");
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h8000_0020, 4'hF, 32'h0);
        cycle(2'b10, 1'b0, "rw_same_rd_new");

        // Address above the mapped range
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(0, 1'b1, 1'b0, 32'h8000_C000, 4'hF, 32'h0);
        cycle(2'b01, RANGE_CHK, "oor_read");
        idle_all();
        cycle(2'b00, 1'b0, "oor_resp");

        // Reset with a response in flight; pointer must return to port 0
        drive(0, 1'b1, 1'b0, 32'h8000_1800, 4'hF, 32'h0);
        cycle(2'b01, 1'b0, "pre_rst_b3");
        sample(2'b01, 1'b0, "rst_grant");
        rst_i = 1'b1;
        q0.delete();
        q1.delete();
        advance();
        drive(1, 1'b1, 1'b0, 32'h8000_1804, 4'hF, 32'h0);
        cycle(2'b00, 1'b0, "in_reset");
        rst_i = 1'b0;
        cycle(2'b01, 1'b0, "ptr_after_rst");
        idle_all();
        cycle(2'b00, 1'b0, "post_rst_resp");
        cycle(2'b00, 1'b0, "quiet");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_bank_xbar.md
SRAM_BANK_XBAR -- requirements
Module: sram_bank_xbar

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of OBI master ports.
REQ-002 SHALL have parameter NUM_BANKS, default 8: number of SRAM banks, power of two, at least 2.
REQ-003 SHALL have parameter BANK_WORDS, default 512: 32-bit words per bank, power of two.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h8000_0000: byte address of bank 0 word 0, aligned to the total size.
REQ-005 SHALL have port clk_i  in  1: the only clock.
REQ-006 SHALL have port rst_i  in  1: reset, asynchronous and active-high.
REQ-007 SHALL have port req_i  in  NUM_PORTS: OBI request, one bit per port.
REQ-008 SHALL have port gnt_o  out  NUM_PORTS: OBI grant.
REQ-009 SHALL have port addr_i  in  NUM_PORTS x 32: byte address.
REQ-010 SHALL have port we_i  in  NUM_PORTS: write enable.
REQ-011 SHALL have port be_i  in  NUM_PORTS x 4: byte enables.
REQ-012 SHALL have port wdata_i  in  NUM_PORTS x 32: write data.
REQ-013 SHALL have port rvalid_o  out  NUM_PORTS: response valid.
REQ-014 SHALL have port rdata_o  out  NUM_PORTS x 32: read data.
REQ-015 SHALL have port err_o  out  NUM_PORTS: response error, qualified by rvalid_o.
REQ-016 SHALL have port illegal_memory_o  out  1: single-cycle pulse on any out-of-range grant.

Function
REQ-017 SHALL compute bank index = addr_i[2+log2(BANK_WORDS) +: log2(NUM_BANKS)] and word index = addr_i[2 +: log2(BANK_WORDS)].
REQ-018 SHALL give each bank its own round-robin arbiter over requesting ports; each bank grants at most one port per cycle.
REQ-019 SHALL assert gnt_o combinationally in the same cycle as req_i when the port wins its bank; a losing port keeps gnt_o=0 and SHALL be granted no later than NUM_PORTS-1 cycles afterwards if it holds req_i.
REQ-020 SHALL advance a bank's priority pointer to winner+1 (mod NUM_PORTS) only on a grant; with no grant the pointer SHALL hold.
REQ-021 SHALL grant, in the same cycle, ports that address different banks.
REQ-022 SHALL drive the winning port's chip select, we, be, wdata and word index to the bank (1rw port of the bank macro; the r port is tied inactive).
REQ-023 SHALL assert rvalid_o exactly one cycle after each grant, for reads and writes alike; rdata_o SHALL be the bank's output for reads and 0 for writes.
REQ-024 SHALL select read data through the bank index registered at grant time, per port; rdata_o SHALL be 0 when rvalid_o=0.
REQ-025 SHALL complete back-to-back grants to one port at one grant per cycle, with no bubble.
REQ-026 SHALL serve a same-cycle read and write to the same bank and word in arbitration order; a read issued after a write SHALL return the new data.

Reset
REQ-027 SHALL on rst_i drive gnt_o, rvalid_o, err_o, illegal_memory_o and rdata_o to 0, clear all priority pointers to port 0 and clear registered bank indices.
REQ-028 SHALL drop responses in flight when reset is asserted mid-operation; no rvalid_o SHALL appear after reset release without a new grant.
REQ-029 SHALL not assert any bank chip select while rst_i=1.

Configuration
REQ-030 SHALL honour macro SRAM_RANGE_CHECK_EN. When defined, a request outside [BASE_ADDR, BASE_ADDR+NUM_BANKS*BANK_WORDS*4) SHALL be granted immediately without bank arbitration or access, followed after one cycle by rvalid_o=1, err_o=1 and rdata_o=0, and illegal_memory_o SHALL pulse for one cycle in the grant cycle.
REQ-031 SHALL, when SRAM_RANGE_CHECK_EN is undefined, ignore the address bits above the bank index (aliasing), tie err_o and illegal_memory_o to 0, and contain no range comparators.

Structure
REQ-032 SHALL place the OBI request/response structs, and log2 helpers for banks and words, in a shared package sram_xbar_pkg.
REQ-033 SHALL implement arbitration in one sub-module rr_arbiter (parameter N; req, gnt one-hot, pointer register), instantiated once per bank.
REQ-034 SHALL instantiate banks in a generate loop over sky130_sram_2kbyte_1rw1r_32x512_8 macros.

Verification
REQ-035 Port0 writes 32'hDEAD_BEEF to 0x8000_0010 with be=4'hF, then reads it back -> gnt in the same cycle, rvalid one cycle later, rdata=32'hDEAD_BEEF.
REQ-036 Both ports read bank 3 continuously from reset -> grants alternate P0,P1,P0,...; each port receives one rvalid every other cycle.
REQ-037 P0 targets bank 0 and P1 targets bank 5 in the same cycle -> both granted; both rvalids arrive in the next cycle with the correct data.
REQ-038 Write be=4'b0010 with data 32'h0000_AB00 over a word holding 32'h1122_3344 -> readback returns 32'h1122_AB44.
REQ-039 With SRAM_RANGE_CHECK_EN defined, read 0x8000_C000 -> gnt=1, illegal_memory_o pulses, next cycle rvalid=1, err=1, rdata=0; without the macro, the same address aliases to 0x8000_0000 and err=0.
REQ-040 rst_i asserted in the cycle after a grant -> rvalid_o stays 0 and the pointers return to port 0.
